// File: rtl/div_seq_unsigned.sv
// div_seq_unsigned: multi-cycle unsigned radix-2 restoring divider returning quotient or remainder.
// Optional build macro DIV_EARLY_OUT_EN: finish in the accept cycle when a < b (b != 0).
//
// state | meaning
// IDLE  | waiting for req_i; operands are latched on the accepting edge
// BUSY  | one restoring iteration per cycle; req_i low aborts back to IDLE
// DONE  | ready_o pulse; result_o already holds the completed value
module div_seq_unsigned #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            is_q_i,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o
);

  localparam int            CW       = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nxt;

  // dq_q starts as the dividend and fills with quotient bits from the LSB end
  logic [XLEN-1:0] dq_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] rem_q;
  logic            is_q_q;
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            step;
  logic            load_res;
  logic            early_hit;
  logic            div_zero;
  logic [XLEN:0]   rem_wide;
  logic [XLEN:0]   diff;
  logic            rem_ge;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] dq_nxt;
  logic [XLEN-1:0] res_nxt;

`ifdef DIV_EARLY_OUT_EN
  assign early_hit = (b_i != '0) && (a_i < b_i);
`else
  assign early_hit = 1'b0;
`endif

  assign div_zero = (dvs_q == '0);

  always_comb begin
    rem_wide = {rem_q, dq_q[XLEN-1]};
    diff     = rem_wide - {1'b0, dvs_q};
    rem_ge   = ~diff[XLEN];
    rem_nxt  = rem_ge ? diff[XLEN-1:0] : rem_wide[XLEN-1:0];
    dq_nxt   = {dq_q[XLEN-2:0], rem_ge};
  end

  // Value captured into result_o on the edge that enters DONE
  always_comb begin
    res_nxt = '0;
    if (state == IDLE) begin
      res_nxt = is_q_i ? '0 : a_i;
    end else if (div_zero) begin
      res_nxt = is_q_q ? '1 : dq_q;
    end else begin
      res_nxt = is_q_q ? dq_nxt : rem_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    load_res  = 1'b0;
    ready_o   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_i) begin
          accept = 1'b1;
          if (early_hit) begin
            state_nxt = DONE;
            load_res  = 1'b1;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req_i) begin
          state_nxt = IDLE;
        end else if (div_zero) begin
          state_nxt = DONE;
          load_res  = 1'b1;
        end else begin
          step = 1'b1;
          if (cnt_q == CNT_ONE) begin
            state_nxt = DONE;
            load_res  = 1'b1;
          end
        end
      end
      DONE: begin
        ready_o   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dq_q     <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      is_q_q   <= 1'b0;
      cnt_q    <= '0;
      result_o <= '0;
    end else begin
      if (accept) begin
        dq_q   <= a_i;
        dvs_q  <= b_i;
        is_q_q <= is_q_i;
        rem_q  <= '0;
        cnt_q  <= CNT_LOAD;
      end else if (step) begin
        dq_q  <= dq_nxt;
        rem_q <= rem_nxt;
        cnt_q <= cnt_q - CNT_ONE;
      end
      if (load_res) begin
        result_o <= res_nxt;
      end
    end
  end

endmodule

// File: tb/tb_div_seq_unsigned.sv
// tb_div_seq_unsigned: directed and randomized operations against an arithmetic model of the divider.
// Build with DIV_EARLY_OUT_EN defined to match an early-out DUT build.
module tb_div_seq_unsigned;

  localparam int XLEN     = 32;
  localparam int FULL_LAT = XLEN + 1;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = FULL_LAT;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            req;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            is_q;
  logic            ready;
  logic [XLEN-1:0] result;

  div_seq_unsigned #(.XLEN(XLEN)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .a_i     (a),
    .b_i     (b),
    .is_q_i  (is_q),
    .ready_o (ready),
    .result_o(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int              n_chk = 0;
  int              n_pass = 0;
  int              exp_ready_cyc = -1;
  logic [XLEN-1:0] exp_done_val = '0;
  logic [XLEN-1:0] exp_result = '0;
  bit              chk_en = 1'b0;

  function automatic logic [XLEN-1:0] model_res(input logic [XLEN-1:0] da, input logic [XLEN-1:0] db,
                                                input logic dq);
    if (db == '0) return dq ? '1 : da;
    return dq ? da / db : da % db;
  endfunction

  function automatic int model_lat(input logic [XLEN-1:0] da, input logic [XLEN-1:0] db);
    bit early;
    early = (db != '0) && (da < db);
    if (db == '0) return 2;
    if (early) return EARLY_LAT;
    return FULL_LAT;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, got, expv, cyc);
  endtask

  // Every cycle: ready_o only in the predicted completion cycle, result_o equal to the last completion
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      if (cyc == exp_ready_cyc) exp_result = exp_done_val;
      chk("ready_o", XLEN'(ready), XLEN'(cyc == exp_ready_cyc));
      chk("result_o", result, exp_result);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0;
      a   = $urandom;
      b   = $urandom;
    end
  endtask

  task automatic run_op(input logic [XLEN-1:0] oa, input logic [XLEN-1:0] ob, input logic oq,
                        input int abort_at, input bit hold_done,
                        output int lat_seen, output logic [XLEN-1:0] res_seen);
    int k;
    bit done;
    lat_seen = -1;
    res_seen = '0;
    done     = 1'b0;
    @(negedge clk);
    req  = 1'b1;
    a    = oa;
    b    = ob;
    is_q = oq;
    @(posedge clk);
    #1;
    k             = cyc;
    exp_done_val  = model_res(oa, ob, oq);
    exp_ready_cyc = k + model_lat(oa, ob) - 1;
    for (int i = 0; i < FULL_LAT + 4 && !done; i++) begin
      if (ready) begin
        lat_seen = cyc - k + 1;
        res_seen = result;
        done     = 1'b1;
      end else if (i == abort_at) begin
        @(negedge clk);
        req           = 1'b0;
        exp_ready_cyc = -1;
        done          = 1'b1;
      end else begin
        @(negedge clk);
        a    = $urandom;
        b    = $urandom;
        is_q = 1'($urandom);
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL timeout: no ready_o within %0d cycles (a=0x%h b=0x%h)", FULL_LAT + 4, oa, ob);
      @(negedge clk);
      req           = 1'b0;
      exp_ready_cyc = -1;
    end else if (lat_seen >= 0) begin
      @(negedge clk);
      req = hold_done ? 1'b1 : 1'($urandom);
      a   = $urandom;
      b   = $urandom;
    end
  endtask

  task automatic directed(input string name, input logic [XLEN-1:0] oa, input logic [XLEN-1:0] ob,
                          input logic oq, input logic [XLEN-1:0] want_res, input int want_lat,
                          input bit hold_done);
    int lat;
    logic [XLEN-1:0] r;
    run_op(oa, ob, oq, -1, hold_done, lat, r);
    chk({name, " result"}, r, want_res);
    chk({name, " latency"}, XLEN'(lat), XLEN'(want_lat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ab;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;
    logic rq;

    rst  = 1'b1;
    req  = 1'b0;
    a    = '0;
    b    = '0;
    is_q = 1'b0;
    #1;
    chk("reset ready_o", XLEN'(ready), '0);
    chk("reset result_o", result, '0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    directed("100/7 q", 32'd100, 32'd7, 1'b1, 32'd14, FULL_LAT, 1'b0);
    directed("100%7 r", 32'd100, 32'd7, 1'b0, 32'd2, FULL_LAT, 1'b0);
    directed("div0 q", 32'h0000_1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 2, 1'b0);
    directed("div0 r", 32'h0000_1234, 32'd0, 1'b0, 32'h0000_1234, 2, 1'b0);
    directed("max/1 q", 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, FULL_LAT, 1'b0);
    directed("max/max r", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, FULL_LAT, 1'b0);
    directed("max/max q", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd1, FULL_LAT, 1'b0);

    // Flush mid-operation: no pulse, result_o keeps the previous quotient
    run_op(32'd50, 32'd5, 1'b1, 9, 1'b0, lat, r);
    idle(1);
    chk("abort result held", result, 32'd1);
    directed("after abort 9/3", 32'd9, 32'd3, 1'b1, 32'd3, FULL_LAT, 1'b0);

    // Asynchronous reset in the middle of BUSY
    @(negedge clk);
    req  = 1'b1;
    a    = 32'd1000;
    b    = 32'd3;
    is_q = 1'b1;
    @(posedge clk);
    #1;
    exp_done_val  = model_res(32'd1000, 32'd3, 1'b1);
    exp_ready_cyc = cyc + FULL_LAT - 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    rst           = 1'b1;
    req           = 1'b0;
    exp_ready_cyc = -1;
    exp_result    = '0;
    #1;
    chk("mid-busy rst ready_o", XLEN'(ready), '0);
    chk("mid-busy rst result_o", result, '0);
    @(negedge clk);
    rst = 1'b0;
    directed("post-reset 100/7", 32'd100, 32'd7, 1'b1, 32'd14, FULL_LAT, 1'b0);

    // Back-to-back: req stays high through DONE into the following IDLE cycle
    directed("b2b first", 32'd200, 32'd10, 1'b1, 32'd20, FULL_LAT, 1'b1);
    directed("b2b second", 32'd201, 32'd10, 1'b0, 32'd1, FULL_LAT, 1'b1);
    directed("a<b 3%10", 32'd3, 32'd10, 1'b0, 32'd3, EARLY_LAT, 1'b0);

    for (int t = 0; t < 60; t++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = XLEN'($urandom_range(1, 15));
        2:       rb = ra + XLEN'($urandom_range(1, 100));
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      rq = 1'($urandom);
      ab = -1;
      if ($urandom_range(0, 9) == 0 && model_lat(ra, rb) >= 2)
        ab = int'($urandom_range(0, model_lat(ra, rb) - 2));
      run_op(ra, rb, rq, ab, 1'($urandom), lat, r);
      if (ab < 0) chk("random result", r, model_res(ra, rb, rq));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(3);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
